// File: rtl/pc_gen_bp.sv
// pc_gen_bp: next-PC generation for instruction fetch.
// Supplies one PC per cycle and holds while the hazard unit stalls.
// On a mispredict it re-steers to the corrected PC. A small direct-mapped
// BTB with 2-bit saturating counters predicts taken branches; execute-stage
// resolutions train it.
// Optional build macro PC_GEN_PERF_EN adds saturating 16-bit counters for
// taken predictions and redirects.
//
// Fetch handshake: fetch consumes PC_ctrl on every rising edge where
// en_ctrl=1. On a mispredict edge, fetch takes pc_reg regardless of en_ctrl.
module pc_gen_bp #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            mispredict,
    input  logic [PC_W-1:0] pc_reg,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic [PC_W-1:0] PC_ctrl,
    output logic            en_ctrl,
    output logic            pred_taken
`ifdef PC_GEN_PERF_EN
    ,
    output logic [15:0]     perf_pred_taken,
    output logic [15:0]     perf_redirect
`endif
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic                             run_q;
    logic [PC_W-1:0]                  pc_q, pc_d;
    logic                             pred_q, pred_d;
    logic [ENTRIES-1:0]               valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]     tgt_q, tgt_d;
    logic [ENTRIES-1:0][1:0]          ctr_q, ctr_d;

    logic [PC_W-1:0]  lk_pc;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic             lk_taken;
    logic [PC_W-1:0]  lk_next;
    logic             load;
    logic [IDX_W-1:0] u_idx;
    logic             u_hit;

    assign en_ctrl    = run_q & ~stall;
    assign PC_ctrl    = pc_q;
    assign pred_taken = pred_q;
    assign load       = mispredict | en_ctrl;

    // Single BTB lookup on whichever PC is about to be replaced: the redirect
    // target on a mispredict, otherwise the PC fetch is consuming.
    // The lookup reads the pre-update table contents.
    always_comb begin
        lk_pc    = mispredict ? pc_reg : pc_q;
        lk_idx   = lk_pc[IDX_W-1:0];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_pc[PC_W-1:IDX_W]);
        lk_taken = lk_hit && ctr_q[lk_idx][1];
        lk_next  = lk_taken ? tgt_q[lk_idx] : lk_pc + PC_W'(1);
    end

    // Next PC and prediction flag: load on a redirect or advance, else hold.
    always_comb begin
        pc_d   = pc_q;
        pred_d = pred_q;
        if (load) begin
            pc_d   = lk_next;
            pred_d = lk_taken;
        end
    end

    // BTB training from execute-stage branch resolution.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        u_idx   = upd_pc[IDX_W-1:0];
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == upd_pc[PC_W-1:IDX_W]);
        if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    tgt_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = upd_pc[PC_W-1:IDX_W];
                tgt_d[u_idx]   = upd_target;
                ctr_d[u_idx]   = 2'b10;
            end
        end
    end

    // State registers; reset returns fetch to PC 0 and clears the BTB.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            pc_q    <= '0;
            pred_q  <= 1'b0;
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else begin
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef PC_GEN_PERF_EN
    logic [15:0] perf_pt_q, perf_pt_d;
    logic [15:0] perf_rd_q, perf_rd_d;

    assign perf_pred_taken = perf_pt_q;
    assign perf_redirect   = perf_rd_q;

    // Saturating event counts: taken predictions loaded, and redirects.
    always_comb begin
        perf_pt_d = perf_pt_q;
        perf_rd_d = perf_rd_q;
        if (load && lk_taken && perf_pt_q != 16'hFFFF) perf_pt_d = perf_pt_q + 16'd1;
        if (mispredict && perf_rd_q != 16'hFFFF) perf_rd_d = perf_rd_q + 16'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_pt_q <= '0;
            perf_rd_q <= '0;
        end else begin
            perf_pt_q <= perf_pt_d;
            perf_rd_q <= perf_rd_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen_bp.sv
// Bench for pc_gen_bp: directed stimulus pushes the expected {pred_taken, PC}
// for every PC fetch will consume. A monitor pops and compares on each
// consuming cycle.
module tb_pc_gen_bp;
    localparam int PC_W = 16;
    localparam int W    = PC_W + 1;

    logic            clk = 1'b0;
    logic            rst, stall, mispredict;
    logic [PC_W-1:0] pc_reg;
    logic            upd_valid, upd_taken;
    logic [PC_W-1:0] upd_pc, upd_target;
    logic [PC_W-1:0] PC_ctrl;
    logic            en_ctrl, pred_taken;
`ifdef PC_GEN_PERF_EN
    logic [15:0]     perf_pred_taken, perf_redirect;
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pc_gen_bp dut (
        .clk(clk), .rst(rst), .stall(stall), .mispredict(mispredict),
        .pc_reg(pc_reg), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .PC_ctrl(PC_ctrl), .en_ctrl(en_ctrl), .pred_taken(pred_taken)
`ifdef PC_GEN_PERF_EN
        , .perf_pred_taken(perf_pred_taken), .perf_redirect(perf_redirect)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [PC_W-1:0] pc, input logic pt);
        exp_q.push_back({pt, pc});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: fetch consumes PC_ctrl on cycles with en_ctrl and no redirect.
    always @(negedge clk) begin
        if (!rst && en_ctrl && !mispredict) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got pc=%h pt=%b expected nothing", PC_ctrl, pred_taken);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({pred_taken, PC_ctrl} !== e) begin
                    errors++;
                    $display("FAIL fetch_pc: got pc=%h pt=%b expected pc=%h pt=%b",
                             PC_ctrl, pred_taken, e[PC_W-1:0], e[PC_W]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1; stall = 1'b0; mispredict = 1'b0; pc_reg = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        cyc(); cyc();
        check("rst_pc", 32'(PC_ctrl), 32'h0);
        check("rst_pred", 32'(pred_taken), 32'h0);
        check("rst_en", 32'(en_ctrl), 32'h0);
        rst = 1'b0;
        #1;
        check("en_first_cycle", 32'(en_ctrl), 32'h0);

        // Sequential run 0..4
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_pc(PC_W'(i), 1'b0);
        end

        // Stall at PC 5 for three cycles
        cyc(); stall = 1'b1; #1;
        check("stall_pc0", 32'(PC_ctrl), 32'h5);
        check("stall_en0", 32'(en_ctrl), 32'h0);
        cyc();
        check("stall_pc1", 32'(PC_ctrl), 32'h5);
        check("stall_en1", 32'(en_ctrl), 32'h0);
        cyc();
        check("stall_pc2", 32'(PC_ctrl), 32'h5);
        cyc(); stall = 1'b0; expect_pc(16'h0005, 1'b0);
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0040;
        cyc(); upd_valid = 1'b0;
        check("stall_release", 32'(PC_ctrl), 32'h6);
        mispredict = 1'b1; pc_reg = 16'h000F;

        // Allocated entry predicts 0x10 -> 0x40
        cyc(); mispredict = 1'b0; expect_pc(16'h0010, 1'b0);
        cyc(); expect_pc(16'h0040, 1'b1);
        cyc(); expect_pc(16'h0041, 1'b0);
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b0;
        cyc(); expect_pc(16'h0042, 1'b0);
        cyc(); expect_pc(16'h0043, 1'b0);
        cyc(); upd_valid = 1'b0;
        mispredict = 1'b1; stall = 1'b1; pc_reg = 16'h000F; #1;
        check("mp_stall_en", 32'(en_ctrl), 32'h0);
        cyc(); mispredict = 1'b0; stall = 1'b0; expect_pc(16'h0010, 1'b0);
        cyc(); expect_pc(16'h0011, 1'b0);

        // Mispredict during stall
        cyc(); mispredict = 1'b1; stall = 1'b1; pc_reg = 16'h0100;
        cyc(); mispredict = 1'b0;
        check("mp_stall_pc", 32'(PC_ctrl), 32'h0101);
        check("mp_stall_pred", 32'(pred_taken), 32'h0);
        check("mp_stall_en2", 32'(en_ctrl), 32'h0);
        cyc();
        check("mp_stall_hold", 32'(PC_ctrl), 32'h0101);
        stall = 1'b0; expect_pc(16'h0101, 1'b0);
        cyc();
        check("pc_0102", 32'(PC_ctrl), 32'h0102);
        mispredict = 1'b1; pc_reg = 16'hFFFE;

        // Wrap 0xFFFF -> 0x0000
        cyc(); mispredict = 1'b0; expect_pc(16'hFFFF, 1'b0);
        cyc(); expect_pc(16'h0000, 1'b0);
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0080;
        cyc();
        check("pc_0001", 32'(PC_ctrl), 32'h0001);
        mispredict = 1'b1; pc_reg = 16'h0010;
        // Same-cycle lookup sees ctr=1 (pre-update)
        cyc(); upd_valid = 1'b0; mispredict = 1'b0; expect_pc(16'h0011, 1'b0);
        cyc(); mispredict = 1'b1; pc_reg = 16'h0010;
        cyc(); mispredict = 1'b0; expect_pc(16'h0080, 1'b1);
        cyc(); expect_pc(16'h0081, 1'b0);

        // Replacement by a different tag at the same index
        cyc();
        upd_valid = 1'b1; upd_pc = 16'h0018; upd_taken = 1'b1; upd_target = 16'h0200;
        mispredict = 1'b1; pc_reg = 16'h0018;
        cyc(); upd_valid = 1'b0; mispredict = 1'b0; expect_pc(16'h0019, 1'b0);
        cyc(); mispredict = 1'b1; pc_reg = 16'h0018;
        cyc(); pc_reg = 16'h0010;
        check("replaced_pc", 32'(PC_ctrl), 32'h0200);
        check("replaced_pred", 32'(pred_taken), 32'h1);
        cyc(); mispredict = 1'b0; expect_pc(16'h0011, 1'b0);
        // Miss with not-taken leaves the entry alone
        upd_valid = 1'b1; upd_pc = 16'h0028; upd_taken = 1'b0;
        cyc(); upd_valid = 1'b0; mispredict = 1'b1; pc_reg = 16'h0018;
        cyc(); mispredict = 1'b0; expect_pc(16'h0200, 1'b1);
        cyc(); expect_pc(16'h0201, 1'b0);
`ifdef PC_GEN_PERF_EN
        check("perf_redirect", 32'(perf_redirect), 32'd10);
        check("perf_pred_taken", 32'(perf_pred_taken), 32'd4);
`endif

        // Reset mid-stream: BTB lost, restart at 0
        cyc(); rst = 1'b1;
        cyc();
        check("rst2_pc", 32'(PC_ctrl), 32'h0);
        check("rst2_en", 32'(en_ctrl), 32'h0);
        check("rst2_pred", 32'(pred_taken), 32'h0);
`ifdef PC_GEN_PERF_EN
        check("rst2_perf_rd", 32'(perf_redirect), 32'd0);
        check("rst2_perf_pt", 32'(perf_pred_taken), 32'd0);
`endif
        rst = 1'b0;
        cyc(); expect_pc(16'h0000, 1'b0);
        cyc(); mispredict = 1'b1; pc_reg = 16'h0018;
        cyc(); mispredict = 1'b0; expect_pc(16'h0019, 1'b0);
        cyc(); stall = 1'b1;
        cyc(); cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
